// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-stage access controller. Sequences a load/store to either the
//   data memory (fixed wait states) or the UART (request held until ack) and
//   stalls the pipeline for the duration of the access.
//
//   Optional feature: define MEM_CTRL_UART_TIMEOUT_EN to abandon a UART
//   access that is not acknowledged within TIMEOUT_CYC cycles (err_o pulse).
//
// Parameters
//   DM_WAIT      data-memory wait states per access (0..15)
//   TIMEOUT_CYC  UART no-ack limit in cycles (1..65535), timeout build only
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  memory-stage instruction is a load or store
//   cs_dm_i      access targets data memory
//   cs_uart_i    access targets UART
//   uart_ack_i   UART has completed the current access
//   stall_o      hold pipeline registers
//   dm_en_o      data-memory access enable
//   uart_req_o   UART request, held until acknowledged
//   done_o       one-cycle pulse when an access completes
//   busy_o       FSM is not in IDLE
//   err_o        one-cycle pulse on a protocol error (or UART timeout)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned DM_WAIT     = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_valid_i,
    input  logic cs_dm_i,
    input  logic cs_uart_i,
    input  logic uart_ack_i,
    output logic stall_o,
    output logic dm_en_o,
    output logic uart_req_o,
    output logic done_o,
    output logic busy_o,
    output logic err_o
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned TO_W   = 16;

    // Elaboration-time parameter range checks
    if (DM_WAIT > 15) begin : g_bad_dm_wait
        $error("mem_access_ctrl: DM_WAIT out of range 0..15");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYC out of range 1..65535");
    end

    // Counter reload: the entry cycle is the first wait state
    localparam logic [WAIT_W-1:0] DM_LOAD = (DM_WAIT > 0) ? WAIT_W'(DM_WAIT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DM_BUSY   = 2'd1,
        UART_BUSY = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;

    logic stall_c;
    logic dm_en_c;
    logic uart_req_c;
    logic done_c;
    logic err_c;

`ifdef MEM_CTRL_UART_TIMEOUT_EN
    // Timeout fires in the cycle the incremented count reaches TIMEOUT_CYC-1
    localparam logic [TO_W:0] TO_LIMIT = (TO_W+1)'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_nxt;
    logic            to_hit;

    assign to_hit = (({1'b0, to_cnt} + (TO_W+1)'(1)) >= TO_LIMIT);
`endif

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
`ifdef MEM_CTRL_UART_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
`ifdef MEM_CTRL_UART_TIMEOUT_EN
            to_cnt   <= to_nxt;
`endif
        end
    end

    // Next-state and same-cycle handshake decode
    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        stall_c    = 1'b0;
        dm_en_c    = 1'b0;
        uart_req_c = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
`ifdef MEM_CTRL_UART_TIMEOUT_EN
        to_nxt     = to_cnt;
`endif

        unique case (state)
            IDLE: begin
                if (req_valid_i) begin
                    if (cs_dm_i && cs_uart_i) begin
                        // Ambiguous decode: flag it and touch neither target
                        err_c = 1'b1;
                    end else if (cs_dm_i) begin
                        dm_en_c = 1'b1;
                        if (DM_WAIT == 0) begin
                            done_c = 1'b1;
                        end else begin
                            stall_c   = 1'b1;
                            wait_nxt  = DM_LOAD;
                            state_nxt = DM_BUSY;
                        end
                    end else if (cs_uart_i) begin
                        uart_req_c = 1'b1;
                        stall_c    = 1'b1;
                        state_nxt  = UART_BUSY;
`ifdef MEM_CTRL_UART_TIMEOUT_EN
                        to_nxt     = '0;
`endif
                    end
                end
            end

            // Request inputs are held by the stalled pipeline, so ignored here
            DM_BUSY: begin
                dm_en_c = 1'b1;
                if (wait_cnt != '0) begin
                    stall_c  = 1'b1;
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end else begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end

            UART_BUSY: begin
                uart_req_c = 1'b1;
                if (uart_ack_i) begin
                    // Ack wins over a coincident timeout
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end else begin
`ifdef MEM_CTRL_UART_TIMEOUT_EN
                    if (to_hit) begin
                        err_c     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stall_c = 1'b1;
                        to_nxt  = to_cnt + TO_W'(1);
                    end
`else
                    stall_c = 1'b1;
`endif
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset blanks everything at once, even with a request still presented
    assign stall_o    = stall_c    & ~rst_i;
    assign dm_en_o    = dm_en_c    & ~rst_i;
    assign uart_req_o = uart_req_c & ~rst_i;
    assign done_o     = done_c     & ~rst_i;
    assign err_o      = err_c      & ~rst_i;
    assign busy_o     = (state != IDLE) & ~rst_i;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl. Instance a uses DM_WAIT=2 and
//   TIMEOUT_CYC=8, instance b uses DM_WAIT=0. Expected output vectors
//   {stall, dm_en, uart_req, done, busy, err} are queued when a step is
//   driven and popped when the outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    // Output vector bits: {stall, dm_en, uart_req, done, busy, err}
    localparam logic [5:0] Z  = 6'b000000;
    localparam logic [5:0] S  = 6'b100000;
    localparam logic [5:0] D  = 6'b010000;
    localparam logic [5:0] U  = 6'b001000;
    localparam logic [5:0] DN = 6'b000100;
    localparam logic [5:0] B  = 6'b000010;
    localparam logic [5:0] E  = 6'b000001;

    // Input vector bits: {req_valid, cs_dm, cs_uart, uart_ack}
    localparam logic [3:0] NI = 4'b0000;
    localparam logic [3:0] RV = 4'b1000;
    localparam logic [3:0] CD = 4'b0100;
    localparam logic [3:0] CU = 4'b0010;
    localparam logic [3:0] AK = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic req_a = 1'b0, cs_dm_a = 1'b0, cs_uart_a = 1'b0, ack_a = 1'b0;
    logic stall_a, dm_en_a, uart_req_a, done_a, busy_a, err_a;

    logic req_b = 1'b0, cs_dm_b = 1'b0, cs_uart_b = 1'b0, ack_b = 1'b0;
    logic stall_b, dm_en_b, uart_req_b, done_b, busy_b, err_b;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DM_WAIT(2), .TIMEOUT_CYC(8)) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_a),
        .cs_dm_i    (cs_dm_a),
        .cs_uart_i  (cs_uart_a),
        .uart_ack_i (ack_a),
        .stall_o    (stall_a),
        .dm_en_o    (dm_en_a),
        .uart_req_o (uart_req_a),
        .done_o     (done_a),
        .busy_o     (busy_a),
        .err_o      (err_a)
    );

    mem_access_ctrl #(.DM_WAIT(0), .TIMEOUT_CYC(255)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_b),
        .cs_dm_i    (cs_dm_b),
        .cs_uart_i  (cs_uart_b),
        .uart_ack_i (ack_b),
        .stall_o    (stall_b),
        .dm_en_o    (dm_en_b),
        .uart_req_o (uart_req_b),
        .done_o     (done_b),
        .busy_o     (busy_b),
        .err_o      (err_b)
    );

    // Queue expectations, let combinational outputs settle, then compare
    task automatic expect_now(input string tag, input logic [5:0] ea, input logic [5:0] eb);
        exp_t       e;
        logic [5:0] obs;
        q_a.push_back('{tag, ea});
        q_b.push_back('{tag, eb});
        #1;
        e   = q_a.pop_front();
        obs = {stall_a, dm_en_a, uart_req_a, done_a, busy_a, err_a};
        vectors++;
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s dut_a observed=%b expected=%b", e.tag, obs, e.exp);
        end
        e   = q_b.pop_front();
        obs = {stall_b, dm_en_b, uart_req_b, done_b, busy_b, err_b};
        vectors++;
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s dut_b observed=%b expected=%b", e.tag, obs, e.exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, check before the rising edge
    task automatic cyc(input string tag, input logic [3:0] ia, input logic [5:0] ea,
                       input logic [3:0] ib, input logic [5:0] eb);
        @(negedge clk);
        {req_a, cs_dm_a, cs_uart_a, ack_a} = ia;
        {req_b, cs_dm_b, cs_uart_b, ack_b} = ib;
        expect_now(tag, ea, eb);
    endtask

    initial begin
        // Reset state, and a request presented during reset is blanked
        expect_now("reset", Z, Z);
        cyc("reset_req", RV | CD, Z, RV | CU, Z);
        cyc("reset_hold", NI, Z, NI, Z);
        rst = 1'b0;

        // Idle with no qualifying request
        cyc("idle_none",    NI,      Z, NI,      Z);
        cyc("idle_nocs",    RV,      Z, RV,      Z);
        cyc("idle_novalid", CD | CU, Z, CD | CU, Z);
        cyc("idle_ack",     AK,      Z, AK,      Z);

        // DM_WAIT=2 access, then an immediate second access with no bubble
        cyc("dm_c0",  RV | CD, S | D,      NI, Z);
        cyc("dm_c1",  RV | CD, S | D | B,  NI, Z);
        cyc("dm_c2",  RV | CD, D | DN | B, NI, Z);
        cyc("b2b_c0", RV | CD, S | D,      NI, Z);
        // Chip-select change while busy must be ignored
        cyc("b2b_c1", RV | CU, S | D | B,  NI, Z);
        cyc("b2b_c2", RV | CU, D | DN | B, NI, Z);

        // UART access accepted straight after, ack in cycle 4
        cyc("uart_c0", RV | CU,      U | S,      NI, Z);
        cyc("uart_c1", RV | CU,      U | S | B,  NI, Z);
        cyc("uart_c2", RV | CD | CU, U | S | B,  NI, Z);
        cyc("uart_c3", RV | CU,      U | S | B,  NI, Z);
        cyc("uart_c4", RV | CU | AK, U | DN | B, NI, Z);
        cyc("uart_c5", NI,           Z,          NI, Z);

        // Ack ignored in IDLE, then honoured on the first busy cycle
        cyc("uack_c0", RV | CU | AK, U | S,      NI, Z);
        cyc("uack_c1", RV | CU | AK, U | DN | B, NI, Z);
        cyc("uack_c2", NI,           Z,          NI, Z);

        // Both chip-selects: single-cycle error, nothing enabled
        cyc("both_cs",  RV | CD | CU, E, RV | CD | CU, E);
        cyc("both_end", NI,           Z, NI,           Z);

        // Zero-wait data memory: three back-to-back single-cycle accesses
        cyc("dm0_a", NI, Z, RV | CD, D | DN);
        cyc("dm0_b", NI, Z, RV | CD, D | DN);
        cyc("dm0_c", NI, Z, RV | CD, D | DN);
        cyc("dm0_uart_c0", NI, Z, RV | CU,      U | S);
        cyc("dm0_uart_c1", NI, Z, RV | CU | AK, U | DN | B);
        cyc("dm0_end",     NI, Z, NI,           Z);

        // Reset asserted mid-cycle while in DM_BUSY
        cyc("rdm_c0", RV | CD, S | D,     NI, Z);
        cyc("rdm_c1", RV | CD, S | D | B, NI, Z);
        rst = 1'b1;
        expect_now("rdm_assert", Z, Z);
        cyc("rdm_hold", NI, Z, NI, Z);
        rst = 1'b0;
        cyc("rdm_after_c0", RV | CD, S | D,      NI, Z);
        cyc("rdm_after_c1", RV | CD, S | D | B,  NI, Z);
        cyc("rdm_after_c2", RV | CD, D | DN | B, NI, Z);
        cyc("rdm_after_c3", NI,      Z,          NI, Z);

        // Reset mid UART access: request dropped, access not resumed
        cyc("ruart_c0", RV | CU, U | S,     NI, Z);
        cyc("ruart_c1", RV | CU, U | S | B, NI, Z);
        rst = 1'b1;
        expect_now("ruart_assert", Z, Z);
        cyc("ruart_hold", NI, Z, NI, Z);
        rst = 1'b0;
        cyc("ruart_after", AK, Z, NI, Z);

`ifdef MEM_CTRL_UART_TIMEOUT_EN
        // No ack: timeout error in cycle 7
        cyc("to_c0", RV | CU, U | S, NI, Z);
        for (int i = 1; i < 7; i++) cyc("to_wait", RV | CU, U | S | B, NI, Z);
        cyc("to_c7", RV | CU, U | E | B, NI, Z);
        cyc("to_c8", NI,      Z,         NI, Z);

        // Ack coinciding with the timeout cycle completes normally
        cyc("tack_c0", RV | CU, U | S, NI, Z);
        for (int i = 1; i < 7; i++) cyc("tack_wait", RV | CU, U | S | B, NI, Z);
        cyc("tack_c7", RV | CU | AK, U | DN | B, NI, Z);
        cyc("tack_c8", NI,           Z,          NI, Z);
`else
        // No timeout: the UART access waits well past TIMEOUT_CYC
        cyc("nto_c0", RV | CU, U | S, NI, Z);
        for (int i = 1; i < 20; i++) cyc("nto_wait", RV | CU, U | S | B, NI, Z);
        cyc("nto_ack", RV | CU | AK, U | DN | B, NI, Z);
        cyc("nto_end", NI,           Z,          NI, Z);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
